writeback_unit: RTL and testbench
=================================

WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 Parameter DEPTH, default 2: number of in-order writeback queue entries (power of two, >=2).
REQ-002 clk  input  1  clock; all state updates on posedge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  MEM stage presents a retiring instruction.
REQ-005 in_ready  output  1  queue can accept; combinational, equals (count < DEPTH).
REQ-006 in_dest  input  5  destination register number.
REQ-007 in_regwrite  input  1  instruction writes a register.
REQ-008 in_sel  input  2  result source: 00 ALU, 01 load, 10 link, 11 none.
REQ-009 in_alu  input  32  ALU result.
REQ-010 in_link  input  32  PC+4 for link instructions.
REQ-011 mem_rvalid  input  1  load data returns this cycle, in program order.
REQ-012 mem_rdata  input  32  returned load data.
REQ-013 write_reg  output  5  register-file write address, registered.
REQ-014 write_data  output  32  register-file write data, registered.
REQ-015 RegWrite  output  1  register-file write enable, registered, one-cycle pulse per retired writing instruction.
REQ-016 fwd_rs, fwd_rt  input  5  decode-stage source register numbers.
REQ-017 fwd_hit_rs, fwd_hit_rt  output  1  combinational bypass hit.
REQ-018 fwd_data_rs, fwd_data_rt  output  32  combinational bypass data.

Function
REQ-019 Accept on posedge when in_valid && in_ready; entry stores dest, effective write flag (in_regwrite && in_dest != 0 && in_sel != 11), and data (ALU or link captured at accept; load marked pending).
REQ-020 in_valid while in_ready=0 shall be ignored; upstream holds the inputs.
REQ-021 mem_rvalid shall complete the oldest pending-load entry, storing mem_rdata; with no pending load it shall be ignored.
REQ-022 mem_rvalid in the same cycle as acceptance of a load shall complete only an already-queued pending load, never the new entry.
REQ-023 Head retires at posedge when complete; at most one retire per cycle; strictly in order.
REQ-024 On retire with write flag set: write_reg/write_data := entry fields, RegWrite := 1; otherwise RegWrite := 0 with write_reg/write_data unchanged.
REQ-025 Latency: non-load entry accepted at edge N into empty queue retires at edge N+1 (RegWrite high during cycle after N+1).
REQ-026 Incomplete head (pending load) blocks retirement of all younger entries.
REQ-027 Simultaneous accept and retire shall both occur; count unchanged; in_ready is not increased by same-cycle retire.
REQ-028 Read/write pointers shall wrap modulo DEPTH.

Reset
REQ-029 rst low: queue emptied, pointers and count 0, write_reg=0, write_data=0, RegWrite=0, fwd_hit_*=0, fwd_data_*=0, immediately and independent of clk.
REQ-030 Reset mid-operation discards all queued and pending-load entries; later mem_rvalid ignored until a new load is accepted.

Configuration
REQ-031 Macro WB_BYPASS_EN defined: fwd_hit_x=1 when a complete queued entry with write flag has dest == fwd_x (youngest match wins); fwd_data_x = its data; never hits for register 0 or pending loads.
REQ-032 WB_BYPASS_EN undefined: bypass logic absent, fwd_hit_* and fwd_data_* tied to 0; ports remain.

Structure
REQ-033 Shared package holds the in_sel encodings (SEL_ALU, SEL_LOAD, SEL_LINK, SEL_NONE) and the entry record typedef (dest, wr, pending, data).
REQ-034 One sub-module wb_queue: DEPTH-entry in-order storage with pointers, count, and oldest-pending-load search; writeback_unit holds retire and bypass logic.

Verification
REQ-035 ALU op dest=5 data=0x1234 into empty queue -> next cycle RegWrite=1, write_reg=5, write_data=0x1234, single pulse.
REQ-036 Load dest=8 then ALU dest=9 data=7; mem_rvalid data=0xCAFE three cycles later -> ALU blocked; retire order reg8=0xCAFE then reg9=7, in_ready=0 while count=2.
REQ-037 dest=0 with in_regwrite=1, sel=ALU -> slot consumed, RegWrite stays 0.
REQ-038 WB_BYPASS_EN, queued complete entries dest=3 data=1 then dest=3 data=2, fwd_rs=3 -> fwd_hit_rs=1, fwd_data_rs=2; pending load dest=4, fwd_rt=4 -> fwd_hit_rt=0.
REQ-039 Queue full with pending-load head, rst pulsed low -> outputs 0 immediately, in_ready=1; following mem_rvalid causes no write.
REQ-040 Continuous back-to-back ALU ops with DEPTH=2 for 10 cycles -> one write per cycle, pointers wrap, no drops.

Source files
------------

// File: rtl/writeback_unit_pkg.sv
// Shared types for the writeback unit: result-source encodings and queue entry record.
package writeback_unit_pkg;

    localparam int unsigned REG_W  = 5;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned SEL_W  = 2;

    typedef enum logic [SEL_W-1:0] {
        SEL_ALU  = 2'b00,
        SEL_LOAD = 2'b01,
        SEL_LINK = 2'b10,
        SEL_NONE = 2'b11
    } sel_e;

    typedef struct packed {
        logic [REG_W-1:0]  dest;
        logic              wr;
        logic              pending;
        logic [DATA_W-1:0] data;
    } entry_t;

    // Build a queue entry from the retiring MEM-stage fields.
    function automatic entry_t make_entry(
        input logic [REG_W-1:0]  dest,
        input logic              regwrite,
        input sel_e              sel,
        input logic [DATA_W-1:0] alu,
        input logic [DATA_W-1:0] link
    );
        entry_t e;
        e.dest    = dest;
        e.wr      = regwrite && (dest != '0) && (sel != SEL_NONE);
        e.pending = (sel == SEL_LOAD);
        case (sel)
            SEL_ALU:  e.data = alu;
            SEL_LINK: e.data = link;
            default:  e.data = '0;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/writeback_unit_wb_queue.sv
// In-order writeback queue: DEPTH entries, wrapping pointers, and completion of the oldest pending load.
module wb_queue
    import writeback_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  entry_t            push_entry,
    input  logic              pop,
    input  logic              complete,
    input  logic [DATA_W-1:0] complete_data,
    output logic              full,
    output entry_t            ordered [DEPTH],
    output logic [DEPTH-1:0]  occupied
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    entry_t          mem [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic            found;
    logic [PW-1:0]   cidx;

    assign full = (count == CW'(DEPTH));

    // Oldest-first view of the queue; the first pending entry is the oldest outstanding load.
    always_comb begin
        found = 1'b0;
        cidx  = rd_ptr;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            ordered[i]  = mem[rd_ptr + PW'(i)];
            occupied[i] = (CW'(i) < count);
            if (!found && occupied[i] && ordered[i].pending) begin
                found = 1'b1;
                cidx  = rd_ptr + PW'(i);
            end
        end
    end

    // A new entry lands at wr_ptr, which is never occupied, so it cannot be completed this cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (complete && found) begin
                mem[cidx].pending <= 1'b0;
                mem[cidx].data    <= complete_data;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: in-order retire into the register file plus optional decode bypass.
// Define WB_BYPASS_EN to build the bypass network; otherwise fwd_hit_*/fwd_data_* are tied to 0.
module writeback_unit
    import writeback_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_W-1:0]  in_dest,
    input  logic              in_regwrite,
    input  logic [SEL_W-1:0]  in_sel,
    input  logic [DATA_W-1:0] in_alu,
    input  logic [DATA_W-1:0] in_link,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [REG_W-1:0]  write_reg,
    output logic [DATA_W-1:0] write_data,
    output logic              RegWrite,
    input  logic [REG_W-1:0]  fwd_rs,
    input  logic [REG_W-1:0]  fwd_rt,
    output logic              fwd_hit_rs,
    output logic              fwd_hit_rt,
    output logic [DATA_W-1:0] fwd_data_rs,
    output logic [DATA_W-1:0] fwd_data_rt
);

    logic             full;
    logic             push;
    logic             pop;
    entry_t           new_entry;
    entry_t           ordered [DEPTH];
    logic [DEPTH-1:0] occupied;

    assign in_ready  = !full;
    assign push      = in_valid && in_ready;
    assign pop       = occupied[0] && !ordered[0].pending;
    assign new_entry = make_entry(in_dest, in_regwrite, sel_e'(in_sel), in_alu, in_link);

    wb_queue #(.DEPTH(DEPTH)) u_queue (
        .clk           (clk),
        .rst           (rst),
        .push          (push),
        .push_entry    (new_entry),
        .pop           (pop),
        .complete      (mem_rvalid),
        .complete_data (mem_rdata),
        .full          (full),
        .ordered       (ordered),
        .occupied      (occupied)
    );

    // Register-file write port; address/data hold their last value between writes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            write_reg  <= '0;
            write_data <= '0;
            RegWrite   <= 1'b0;
        end else begin
            RegWrite <= pop && ordered[0].wr;
            if (pop && ordered[0].wr) begin
                write_reg  <= ordered[0].dest;
                write_data <= ordered[0].data;
            end
        end
    end

`ifdef WB_BYPASS_EN
    // Scan oldest to youngest so the youngest matching complete writer wins; wr excludes r0.
    always_comb begin
        fwd_hit_rs  = 1'b0;
        fwd_hit_rt  = 1'b0;
        fwd_data_rs = '0;
        fwd_data_rt = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (occupied[i] && ordered[i].wr && !ordered[i].pending) begin
                if (ordered[i].dest == fwd_rs) begin
                    fwd_hit_rs  = 1'b1;
                    fwd_data_rs = ordered[i].data;
                end
                if (ordered[i].dest == fwd_rt) begin
                    fwd_hit_rt  = 1'b1;
                    fwd_data_rt = ordered[i].data;
                end
            end
        end
    end
`else
    logic unused_bypass;
    assign unused_bypass = ^{fwd_rs, fwd_rt, occupied, ordered[DEPTH-1]};

    assign fwd_hit_rs  = 1'b0;
    assign fwd_hit_rt  = 1'b0;
    assign fwd_data_rs = '0;
    assign fwd_data_rt = '0;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: vector table plus hand sequences, scoreboarded writes.
module tb_writeback_unit;
    import writeback_unit_pkg::*;

    localparam int unsigned DEPTH = 2;
`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_regwrite, mem_rvalid;
    logic [4:0]  in_dest, fwd_rs, fwd_rt, write_reg;
    logic [1:0]  in_sel;
    logic [31:0] in_alu, in_link, mem_rdata, write_data, fwd_data_rs, fwd_data_rt;
    logic        reg_write, fwd_hit_rs, fwd_hit_rt;

    writeback_unit #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_dest(in_dest),
        .in_regwrite(in_regwrite), .in_sel(in_sel), .in_alu(in_alu), .in_link(in_link),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .write_reg(write_reg),
        .write_data(write_data), .RegWrite(reg_write), .fwd_rs(fwd_rs), .fwd_rt(fwd_rt),
        .fwd_hit_rs(fwd_hit_rs), .fwd_hit_rt(fwd_hit_rt), .fwd_data_rs(fwd_data_rs),
        .fwd_data_rt(fwd_data_rt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic        rw;
        logic [1:0]  sel;
        logic [4:0]  dest;
        logic [31:0] alu;
        logic [31:0] link;
        logic        exp_wr;
        logic [31:0] exp_data;
    } vec_t;

    wr_t  sb[$];
    vec_t vt[14];
    int   n_vec = 0;
    int   n_err = 0;
    int   n_writes = 0;
    bit   mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every register-file write must match the oldest expected write.
    always @(negedge clk) begin
        if (rst && mon_en && reg_write) begin
            n_writes++;
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_write: got reg %0d data 0x%0h expected none", write_reg, write_data);
            end else begin
                wr_t e;
                e = sb.pop_front();
                check("wb_reg", 32'(write_reg), 32'(e.rd));
                check("wb_data", write_data, e.data);
            end
        end
    end

    task automatic send(input logic rw, input logic [1:0] sel, input logic [4:0] dest,
                        input logic [31:0] alu, input logic [31:0] link,
                        input bit rv, input logic [31:0] rvd,
                        input logic exp_wr, input logic [31:0] exp_data, output int waits);
        wr_t e;
        in_valid = 1'b1; in_regwrite = rw; in_sel = sel; in_dest = dest;
        in_alu = alu; in_link = link; mem_rvalid = rv; mem_rdata = rvd;
        waits = 0;
        while (!in_ready && waits < 50) begin
            @(posedge clk); #1;
            mem_rvalid = 1'b0;
            waits++;
        end
        if (!in_ready) begin
            n_vec++; n_err++;
            $display("FAIL accept_timeout: got in_ready 0 expected 1");
            in_valid = 1'b0;
            return;
        end
        if (exp_wr) begin
            e.rd = dest; e.data = exp_data;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        mem_rvalid = 1'b0;
    endtask

    task automatic mem_return(input logic [31:0] d);
        mem_rvalid = 1'b1; mem_rdata = d;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drain(input string name);
        int t = 0;
        while (sb.size() != 0 && t < 50) begin @(posedge clk); #1; t++; end
        idle(1);
        check(name, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int base;
        vt[0]  = '{1'b1, SEL_ALU,  5'd1,  32'h11,        32'h0,    1'b1, 32'h11};
        vt[1]  = '{1'b1, SEL_LINK, 5'd2,  32'h22,        32'h2004, 1'b1, 32'h2004};
        vt[2]  = '{1'b1, SEL_ALU,  5'd3,  32'h33,        32'h0,    1'b1, 32'h33};
        vt[3]  = '{1'b1, SEL_LINK, 5'd31, 32'h0,         32'h1008, 1'b1, 32'h1008};
        vt[4]  = '{1'b1, SEL_ALU,  5'd4,  32'hdead_beef, 32'h0,    1'b1, 32'hdead_beef};
        vt[5]  = '{1'b1, SEL_ALU,  5'd5,  32'h0,         32'h4,    1'b1, 32'h0};
        vt[6]  = '{1'b1, SEL_LINK, 5'd6,  32'hffff,      32'h100c, 1'b1, 32'h100c};
        vt[7]  = '{1'b1, SEL_ALU,  5'd7,  32'h7777_0000, 32'h0,    1'b1, 32'h7777_0000};
        vt[8]  = '{1'b1, SEL_ALU,  5'd30, 32'hffff_ffff, 32'h0,    1'b1, 32'hffff_ffff};
        vt[9]  = '{1'b1, SEL_ALU,  5'd1,  32'habc,       32'h0,    1'b1, 32'habc};
        vt[10] = '{1'b1, SEL_ALU,  5'd0,  32'h55,        32'h0,    1'b0, 32'h0};
        vt[11] = '{1'b1, SEL_NONE, 5'd9,  32'h66,        32'h0,    1'b0, 32'h0};
        vt[12] = '{1'b0, SEL_ALU,  5'd9,  32'h77,        32'h0,    1'b0, 32'h0};
        vt[13] = '{1'b1, SEL_LINK, 5'd0,  32'h88,        32'h2000, 1'b0, 32'h0};

        rst = 1'b0; in_valid = 1'b0; in_regwrite = 1'b0; in_sel = 2'b00; in_dest = '0;
        in_alu = '0; in_link = '0; mem_rvalid = 1'b0; mem_rdata = '0; fwd_rs = '0; fwd_rt = '0;
        #1;
        check("rst_regwrite", 32'(reg_write), 32'd0);
        check("rst_write_reg", 32'(write_reg), 32'd0);
        check("rst_write_data", write_data, 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_fwd_hit", 32'({fwd_hit_rs, fwd_hit_rt}), 32'd0);
        #11 rst = 1'b1;
        @(posedge clk); #1;
        mon_en = 1'b1;

        // Single ALU op: write appears the cycle after retire, one pulse.
        send(1'b1, SEL_ALU, 5'd5, 32'h1234, 32'h0, 1'b0, 32'h0, 1'b1, 32'h1234, w);
        check("lat_no_stall", 32'(w), 32'd0);
        @(negedge clk);
        check("lat_early", 32'(reg_write), 32'd0);
        @(negedge clk);
        check("lat_regwrite", 32'(reg_write), 32'd1);
        check("lat_reg", 32'(write_reg), 32'd5);
        check("lat_data", write_data, 32'h1234);
        @(negedge clk);
        check("lat_single_pulse", 32'(reg_write), 32'd0);
        @(posedge clk); #1;

        // Back-to-back stream from the table, including non-writing entries.
        base = n_writes;
        for (int i = 0; i < 14; i++) begin
            send(vt[i].rw, vt[i].sel, vt[i].dest, vt[i].alu, vt[i].link, 1'b0, 32'h0,
                 vt[i].exp_wr, vt[i].exp_data, w);
            check($sformatf("stream_stall_%0d", i), 32'(w), 32'd0);
        end
        drain("stream_drain");
        check("stream_write_count", 32'(n_writes - base), 32'd10);

        // Pending load head blocks the younger ALU op.
        send(1'b1, SEL_LOAD, 5'd8, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 32'hcafe, w);
        send(1'b1, SEL_ALU, 5'd9, 32'h7, 32'h0, 1'b0, 32'h0, 1'b1, 32'h7, w);
        check("full_in_ready", 32'(in_ready), 32'd0);
        base = n_writes;
        idle(2);
        check("blocked_no_write", 32'(n_writes - base), 32'd0);
        check("still_full", 32'(in_ready), 32'd0);
        mem_return(32'hcafe);
        drain("load_drain");
        check("load_write_count", 32'(n_writes - base), 32'd2);

        // Return in the cycle a second load is accepted completes only the older one.
        send(1'b1, SEL_LOAD, 5'd12, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 32'ha, w);
        base = n_writes;
        send(1'b1, SEL_LOAD, 5'd13, 32'h0, 32'h0, 1'b1, 32'ha, 1'b1, 32'hb, w);
        idle(3);
        check("same_cycle_one_retire", 32'(n_writes - base), 32'd1);
        check("same_cycle_ready", 32'(in_ready), 32'd1);
        mem_return(32'hb);
        drain("same_cycle_drain");

        // Bypass: pending loads never hit, complete entries do, youngest wins.
        send(1'b1, SEL_LOAD, 5'd4, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h44, w);
        send(1'b1, SEL_ALU, 5'd3, 32'h1, 32'h0, 1'b0, 32'h0, 1'b1, 32'h1, w);
        fwd_rs = 5'd3; fwd_rt = 5'd4;
        #1;
        check("byp_rs_hit", 32'(fwd_hit_rs), 32'(BYP));
        check("byp_rs_data", fwd_data_rs, BYP ? 32'h1 : 32'h0);
        check("byp_pending_rt_hit", 32'(fwd_hit_rt), 32'd0);
        check("byp_pending_rt_data", fwd_data_rt, 32'h0);
        mem_return(32'h44);
        check("byp_done_rt_hit", 32'(fwd_hit_rt), 32'(BYP));
        check("byp_done_rt_data", fwd_data_rt, BYP ? 32'h44 : 32'h0);
        drain("byp_drain1");
        send(1'b1, SEL_LOAD, 5'd3, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h1, w);
        send(1'b1, SEL_ALU, 5'd3, 32'h2, 32'h0, 1'b0, 32'h0, 1'b1, 32'h2, w);
        mem_return(32'h1);
        fwd_rt = 5'd0;
        #1;
        check("byp_youngest_hit", 32'(fwd_hit_rs), 32'(BYP));
        check("byp_youngest_data", fwd_data_rs, BYP ? 32'h2 : 32'h0);
        check("byp_r0_hit", 32'(fwd_hit_rt), 32'd0);
        drain("byp_drain2");

        // Asynchronous reset with a full queue and a pending-load head.
        send(1'b1, SEL_LOAD, 5'd10, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, w);
        send(1'b1, SEL_ALU, 5'd11, 32'h5, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, w);
        fwd_rs = 5'd11;
        check("pre_rst_full", 32'(in_ready), 32'd0);
        #3 rst = 1'b0;
        #1;
        check("arst_regwrite", 32'(reg_write), 32'd0);
        check("arst_write_reg", 32'(write_reg), 32'd0);
        check("arst_write_data", write_data, 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        check("arst_fwd_hit", 32'(fwd_hit_rs), 32'd0);
        check("arst_fwd_data", fwd_data_rs, 32'd0);
        sb.delete();
        @(negedge clk); #2 rst = 1'b1;
        @(posedge clk); #1;
        base = n_writes;
        mem_return(32'h999);
        idle(3);
        check("post_rst_no_write", 32'(n_writes - base), 32'd0);
        check("post_rst_write_reg", 32'(write_reg), 32'd0);

        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
